// File: rtl/drac_pkg.sv
// Shared types for the Lagarto dcache port arbiter.
// Optional perf counters: LAGARTO_DCACHE_ARB_PERF_EN.
package drac_pkg;

  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH = 28;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LD_WAIT,
    ARB_DROP
  } arb_state_t;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [63:0]                   wdata;
    logic [7:0]                    be;
    logic [1:0]                    size;
  } stb_entry_t;

  // Same 8-byte word: tag and index above the byte offset.
  function automatic logic same_word(
    input logic [DCACHE_TAG_WIDTH-1:0]   tag_a,
    input logic [DCACHE_INDEX_WIDTH-1:0] idx_a,
    input logic [DCACHE_TAG_WIDTH-1:0]   tag_b,
    input logic [DCACHE_INDEX_WIDTH-1:0] idx_b
  );
    return (tag_a == tag_b) &&
      (idx_a[DCACHE_INDEX_WIDTH-1:3] ==
       idx_b[DCACHE_INDEX_WIDTH-1:3]);
  endfunction

endpackage

// File: rtl/lagarto_dcache_port_arbiter_if.sv
// Load, store and dcache channels of the port arbiter.
// Directions named from the arbiter side (slave modport).
interface lagarto_dcache_port_arbiter_if;
  import drac_pkg::*;

  logic                          ld_valid_i;
  logic                          ld_ready_o;
  logic [DCACHE_INDEX_WIDTH-1:0] ld_addr_index_i;
  logic [DCACHE_TAG_WIDTH-1:0]   ld_addr_tag_i;
  logic [7:0]                    ld_be_i;
  logic [1:0]                    ld_size_i;
  logic                          ld_kill_i;
  logic                          ld_resp_valid_o;
  logic [63:0]                   ld_resp_data_o;
  logic                          st_valid_i;
  logic                          st_ready_o;
  logic [DCACHE_INDEX_WIDTH-1:0] st_addr_index_i;
  logic [DCACHE_TAG_WIDTH-1:0]   st_addr_tag_i;
  logic [63:0]                   st_wdata_i;
  logic [7:0]                    st_be_i;
  logic [1:0]                    st_size_i;
  logic                          stb_empty_o;
  logic                          req_valid_o;
  logic                          req_ready_i;
  logic                          req_we_o;
  logic [DCACHE_INDEX_WIDTH-1:0] req_addr_index_o;
  logic [DCACHE_TAG_WIDTH-1:0]   req_addr_tag_o;
  logic [63:0]                   req_wdata_o;
  logic [7:0]                    req_be_o;
  logic [1:0]                    req_size_o;
  logic                          req_kill_o;
  logic                          resp_valid_i;
  logic [63:0]                   resp_data_i;

  modport slave (
    input  ld_valid_i, ld_addr_index_i, ld_addr_tag_i,
    input  ld_be_i, ld_size_i, ld_kill_i,
    output ld_ready_o, ld_resp_valid_o, ld_resp_data_o,
    input  st_valid_i, st_addr_index_i, st_addr_tag_i,
    input  st_wdata_i, st_be_i, st_size_i,
    output st_ready_o, stb_empty_o,
    output req_valid_o, req_we_o, req_addr_index_o,
    output req_addr_tag_o, req_wdata_o, req_be_o,
    output req_size_o, req_kill_o,
    input  req_ready_i, resp_valid_i, resp_data_i
  );

  modport master (
    output ld_valid_i, ld_addr_index_i, ld_addr_tag_i,
    output ld_be_i, ld_size_i, ld_kill_i,
    input  ld_ready_o, ld_resp_valid_o, ld_resp_data_o,
    output st_valid_i, st_addr_index_i, st_addr_tag_i,
    output st_wdata_i, st_be_i, st_size_i,
    input  st_ready_o, stb_empty_o,
    input  req_valid_o, req_we_o, req_addr_index_o,
    input  req_addr_tag_o, req_wdata_o, req_be_o,
    input  req_size_o, req_kill_o,
    output req_ready_i, resp_valid_i, resp_data_i
  );

endinterface

// File: rtl/lagarto_dcache_port_arbiter_stb.sv
// In-order store buffer with associative load hazard compare.
module lagarto_dcache_stb
  import drac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          push_i,
  input  stb_entry_t                    push_entry_i,
  input  logic                          pop_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   ld_tag_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] ld_index_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          hazard_o,
  output stb_entry_t                    head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  stb_entry_t     mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (pop_i) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + PW'(1);
      end
      if (push_i) begin
        vld_q[wr_q] <= 1'b1;
        wr_q        <= wr_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Payload needs no reset: validity lives in vld_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_entry_i;
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && same_word(mem_q[i].tag,
          mem_q[i].index, ld_tag_i, ld_index_i))
        hazard_o = 1'b1;
    end
  end

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/lagarto_dcache_port_arbiter.sv
// Load/store arbiter for the single L1 dcache port.
// Optional perf counters: LAGARTO_DCACHE_ARB_PERF_EN.
module lagarto_dcache_port_arbiter
  import drac_pkg::*;
#(
  parameter int STB_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input logic clk_i,
  input logic rstn_i,
  lagarto_dcache_port_arbiter_if.slave bus
`ifdef LAGARTO_DCACHE_ARB_PERF_EN
  ,
  output logic [31:0] perf_ld_hazard_cnt_o,
  output logic [31:0] perf_st_forced_cnt_o
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state_q;
  logic [SW-1:0] starve_q;
  logic          lock_st_q;
  logic          lock_ld_q;
  logic          full, empty, hazard;
  stb_entry_t    head, st_entry;
  logic          idle, waiting, ld_pres, starved;
  logic          st_sel, ld_sel, st_gnt, ld_gnt, push;

  assign st_entry = '{
    tag:   bus.st_addr_tag_i,
    index: bus.st_addr_index_i,
    wdata: bus.st_wdata_i,
    be:    bus.st_be_i,
    size:  bus.st_size_i
  };

  assign push = bus.st_valid_i && bus.st_ready_o;

  lagarto_dcache_stb #(.DEPTH(STB_DEPTH)) u_stb (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .push_entry_i(st_entry),
    .pop_i       (st_gnt),
    .ld_tag_i    (bus.ld_addr_tag_i),
    .ld_index_i  (bus.ld_addr_index_i),
    .full_o      (full),
    .empty_o     (empty),
    .hazard_o    (hazard),
    .head_o      (head)
  );

  assign idle    = rstn_i && state_q == ARB_IDLE;
  assign waiting = rstn_i && state_q == ARB_LD_WAIT;
  assign ld_pres = bus.ld_valid_i && !bus.ld_kill_i;
  assign starved = starve_q == SW'(STARVE_MAX);

  // A presented but unaccepted request keeps its slot.
  always_comb begin
    st_sel = 1'b0;
    ld_sel = 1'b0;
    if (idle) begin
      if (lock_st_q)
        st_sel = 1'b1;
      else if (lock_ld_q && ld_pres && !hazard)
        ld_sel = 1'b1;
      else if (!empty &&
          (full || starved || hazard || !ld_pres))
        st_sel = 1'b1;
      else
        ld_sel = ld_pres;
    end
  end

  assign st_gnt = st_sel && bus.req_ready_i;
  assign ld_gnt = ld_sel && bus.req_ready_i;

  assign bus.st_ready_o  = rstn_i && !full;
  assign bus.stb_empty_o = empty;
  assign bus.ld_ready_o  = ld_gnt;
  assign bus.req_valid_o = st_sel || ld_sel;
  assign bus.req_we_o    = st_sel;

  assign bus.req_addr_index_o =
    st_sel ? head.index :
    ld_sel ? bus.ld_addr_index_i : '0;
  assign bus.req_addr_tag_o =
    st_sel ? head.tag :
    ld_sel ? bus.ld_addr_tag_i : '0;
  assign bus.req_be_o =
    st_sel ? head.be :
    ld_sel ? bus.ld_be_i : '0;
  assign bus.req_size_o =
    st_sel ? head.size :
    ld_sel ? bus.ld_size_i : '0;
  assign bus.req_wdata_o = st_sel ? head.wdata : '0;

  assign bus.req_kill_o      = waiting && bus.ld_kill_i;
  assign bus.ld_resp_valid_o =
    waiting && bus.resp_valid_i && !bus.ld_kill_i;
  assign bus.ld_resp_data_o  =
    bus.ld_resp_valid_o ? bus.resp_data_i : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ARB_IDLE;
      starve_q  <= '0;
      lock_st_q <= 1'b0;
      lock_ld_q <= 1'b0;
    end else begin
      lock_st_q <= st_sel && !bus.req_ready_i;
      lock_ld_q <= ld_sel && !bus.req_ready_i;
      if (empty || st_gnt)
        starve_q <= '0;
      else if (ld_gnt && !starved)
        starve_q <= starve_q + SW'(1);
      unique case (state_q)
        ARB_IDLE:
          if (ld_gnt) state_q <= ARB_LD_WAIT;
        ARB_LD_WAIT:
          if (bus.resp_valid_i) state_q <= ARB_IDLE;
          else if (bus.ld_kill_i) state_q <= ARB_DROP;
        ARB_DROP:
          if (bus.resp_valid_i) state_q <= ARB_IDLE;
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef LAGARTO_DCACHE_ARB_PERF_EN
  logic [31:0] hz_cnt_q;
  logic [31:0] fc_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hz_cnt_q <= '0;
      fc_cnt_q <= '0;
    end else begin
      if (idle && ld_pres && hazard)
        hz_cnt_q <= hz_cnt_q + 32'd1;
      if (st_gnt && (full || starved))
        fc_cnt_q <= fc_cnt_q + 32'd1;
    end
  end

  assign perf_ld_hazard_cnt_o = hz_cnt_q;
  assign perf_st_forced_cnt_o = fc_cnt_q;
`endif

endmodule

// File: tb/tb_lagarto_dcache_port_arbiter.sv
// Directed testbench for lagarto_dcache_port_arbiter.
module tb_lagarto_dcache_port_arbiter;
  import drac_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  lagarto_dcache_port_arbiter_if bus ();

  lagarto_dcache_port_arbiter dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_valid_i      = 1'b0;
    bus.ld_addr_index_i = '0;
    bus.ld_addr_tag_i   = '0;
    bus.ld_be_i         = '0;
    bus.ld_size_i       = '0;
    bus.ld_kill_i       = 1'b0;
    bus.st_valid_i      = 1'b0;
    bus.st_addr_index_i = '0;
    bus.st_addr_tag_i   = '0;
    bus.st_wdata_i      = '0;
    bus.st_be_i         = '0;
    bus.st_size_i       = '0;
    bus.req_ready_i     = 1'b0;
    bus.resp_valid_i    = 1'b0;
    bus.resp_data_i     = '0;
  endtask

  task automatic drive_ld(input logic [27:0] tag,
                          input logic [11:0] idx);
    bus.ld_valid_i      = 1'b1;
    bus.ld_addr_tag_i   = tag;
    bus.ld_addr_index_i = idx;
    bus.ld_be_i         = 8'hFF;
    bus.ld_size_i       = 2'd3;
  endtask

  task automatic drive_st(input logic [27:0] tag,
                          input logic [11:0] idx,
                          input logic [63:0] data);
    bus.st_valid_i      = 1'b1;
    bus.st_addr_tag_i   = tag;
    bus.st_addr_index_i = idx;
    bus.st_wdata_i      = data;
    bus.st_be_i         = 8'hFF;
    bus.st_size_i       = 2'd3;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    flags = {bus.req_valid_o, bus.req_we_o,
             bus.ld_ready_o, bus.st_ready_o,
             bus.ld_resp_valid_o, bus.req_kill_o,
             bus.stb_empty_o};
    tests++;
    if (flags !== 7'b0000001) begin
      $display("FAIL reset_flags got %b want %b",
               flags, 7'b0000001);
      fails++;
    end
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_load();
    drive_ld(28'h12, 12'h040);
    bus.req_ready_i = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.req_valid_o, bus.req_we_o, bus.ld_ready_o,
         bus.req_addr_tag_o} !== {3'b101, 28'h12}) begin
      $display("FAIL load_issue v=%b we=%b rdy=%b tag=%h want 1,0,1,12",
               bus.req_valid_o, bus.req_we_o,
               bus.ld_ready_o, bus.req_addr_tag_o);
      fails++;
    end
    step();
    bus.ld_valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_valid_o !== 1'b0) begin
      $display("FAIL load_wait_quiet req_valid=%b want 0",
               bus.req_valid_o);
      fails++;
    end
    step();
    bus.resp_valid_i = 1'b1;
    bus.resp_data_i  = 64'hDEADBEEF;
    @(negedge clk);
    tests++;
    if ({bus.ld_resp_valid_o, bus.ld_resp_data_o} !==
        {1'b1, 64'hDEADBEEF}) begin
      $display("FAIL load_resp v=%b data=%h want 1 deadbeef",
               bus.ld_resp_valid_o, bus.ld_resp_data_o);
      fails++;
    end
    step();
    bus.resp_valid_i = 1'b0;
    bus.req_ready_i  = 1'b0;
    drive_ld(28'h13, 12'h080);
    @(negedge clk);
    tests++;
    if (bus.req_valid_o !== 1'b1) begin
      $display("FAIL load_back_idle req_valid=%b want 1",
               bus.req_valid_o);
      fails++;
    end
    step();
    bus.ld_valid_i = 1'b0;
    step();
  endtask

  task automatic test_stb_fill_drain();
    int bad_order = 0;
    bus.req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_st(28'h100 + 28'(i), 12'h100 + 12'(i * 8),
               64'hA0 + 64'(i));
      step();
    end
    @(negedge clk);
    tests++;
    if ({bus.st_ready_o, bus.stb_empty_o, bus.req_we_o,
         bus.req_wdata_o} !== {3'b001, 64'hA0}) begin
      $display("FAIL stb_full rdy=%b empty=%b we=%b wdata=%h want 0,0,1,a0",
               bus.st_ready_o, bus.stb_empty_o,
               bus.req_we_o, bus.req_wdata_o);
      fails++;
    end
    step();
    bus.st_valid_i  = 1'b0;
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!(bus.req_valid_o && bus.req_we_o &&
            bus.req_wdata_o == 64'hA0 + 64'(i) &&
            bus.req_addr_tag_o == 28'h100 + 28'(i)))
        bad_order++;
      step();
    end
    tests++;
    if (bad_order !== 0) begin
      $display("FAIL stb_fifo_order bad=%0d want 0",
               bad_order);
      fails++;
    end
    @(negedge clk);
    tests++;
    if ({bus.stb_empty_o, bus.req_valid_o} !== 2'b10) begin
      $display("FAIL stb_drained empty=%b req_valid=%b want 1 0",
               bus.stb_empty_o, bus.req_valid_o);
      fails++;
    end
    step();
    bus.req_ready_i = 1'b0;
  endtask

  task automatic test_hazard();
    bus.req_ready_i = 1'b0;
    drive_st(28'h55, 12'h048, 64'h5555);
    step();
    bus.st_valid_i = 1'b0;
    drive_ld(28'h55, 12'h048);
    @(negedge clk);
    tests++;
    if ({bus.req_we_o, bus.ld_ready_o} !== 2'b10) begin
      $display("FAIL hazard_block we=%b ld_ready=%b want 1 0",
               bus.req_we_o, bus.ld_ready_o);
      fails++;
    end
    step();
    bus.req_ready_i = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.req_we_o, bus.ld_ready_o,
         bus.req_addr_index_o} !== {2'b10, 12'h048}) begin
      $display("FAIL hazard_store_first we=%b rdy=%b idx=%h want 1,0,048",
               bus.req_we_o, bus.ld_ready_o,
               bus.req_addr_index_o);
      fails++;
    end
    step();
    @(negedge clk);
    tests++;
    if ({bus.req_valid_o, bus.req_we_o,
         bus.ld_ready_o} !== 3'b101) begin
      $display("FAIL hazard_load_after v=%b we=%b rdy=%b want 1,0,1",
               bus.req_valid_o, bus.req_we_o,
               bus.ld_ready_o);
      fails++;
    end
    step();
    bus.ld_valid_i   = 1'b0;
    bus.resp_valid_i = 1'b1;
    step();
    bus.resp_valid_i = 1'b0;
    bus.req_ready_i  = 1'b0;
  endtask

  task automatic test_starvation();
    int ld_grants = 0;
    bus.req_ready_i = 1'b0;
    drive_st(28'h77, 12'h200, 64'h7777);
    step();
    bus.st_valid_i  = 1'b0;
    drive_ld(28'h11, 12'h010);
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.resp_valid_i = 1'b0;
      @(negedge clk);
      if (bus.req_valid_o && !bus.req_we_o &&
          bus.ld_ready_o)
        ld_grants++;
      step();
      bus.resp_valid_i = 1'b1;
      bus.resp_data_i  = 64'(i);
      step();
    end
    bus.resp_valid_i = 1'b0;
    tests++;
    if (ld_grants !== 8) begin
      $display("FAIL starve_load_grants got %0d want 8",
               ld_grants);
      fails++;
    end
    @(negedge clk);
    tests++;
    if ({bus.req_we_o, bus.ld_ready_o,
         bus.req_addr_tag_o} !== {2'b10, 28'h77}) begin
      $display("FAIL starve_forced we=%b rdy=%b tag=%h want 1,0,77",
               bus.req_we_o, bus.ld_ready_o,
               bus.req_addr_tag_o);
      fails++;
    end
    step();
    bus.ld_valid_i  = 1'b0;
    bus.req_ready_i = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.stb_empty_o !== 1'b1) begin
      $display("FAIL starve_empty got %b want 1",
               bus.stb_empty_o);
      fails++;
    end
    step();
  endtask

  task automatic test_kill();
    drive_ld(28'h21, 12'h020);
    bus.req_ready_i = 1'b1;
    step();
    bus.ld_valid_i = 1'b0;
    bus.ld_kill_i  = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.req_kill_o !== 1'b1) begin
      $display("FAIL kill_pulse got %b want 1",
               bus.req_kill_o);
      fails++;
    end
    step();
    bus.ld_kill_i = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_kill_o !== 1'b0) begin
      $display("FAIL kill_one_cycle got %b want 0",
               bus.req_kill_o);
      fails++;
    end
    step();
    bus.resp_valid_i = 1'b1;
    bus.resp_data_i  = 64'h1234;
    @(negedge clk);
    tests++;
    if ({bus.ld_resp_valid_o, bus.ld_resp_data_o} !==
        {1'b0, 64'h0}) begin
      $display("FAIL kill_drop v=%b data=%h want 0 0",
               bus.ld_resp_valid_o, bus.ld_resp_data_o);
      fails++;
    end
    step();
    bus.resp_valid_i = 1'b0;
    bus.req_ready_i  = 1'b0;
    drive_ld(28'h22, 12'h028);
    bus.ld_kill_i = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.req_valid_o !== 1'b0) begin
      $display("FAIL kill_withdraw req_valid=%b want 0",
               bus.req_valid_o);
      fails++;
    end
    bus.ld_kill_i = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_valid_o !== 1'b1) begin
      $display("FAIL kill_back_idle req_valid=%b want 1",
               bus.req_valid_o);
      fails++;
    end
    step();
    bus.ld_valid_i = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    logic [6:0] flags;
    drive_ld(28'h31, 12'h030);
    drive_st(28'h300, 12'h300, 64'h3000);
    bus.req_ready_i = 1'b1;
    step();
    bus.ld_valid_i = 1'b0;
    drive_st(28'h301, 12'h308, 64'h3001);
    step();
    bus.st_valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.stb_empty_o, bus.req_valid_o} !== 2'b00) begin
      $display("FAIL arst_setup empty=%b req_valid=%b want 0 0",
               bus.stb_empty_o, bus.req_valid_o);
      fails++;
    end
    drive_ld(28'h32, 12'h038);
    bus.st_valid_i   = 1'b1;
    bus.resp_valid_i = 1'b1;
    bus.resp_data_i  = 64'hFFFF;
    #1;
    rstn = 1'b0;
    #1;
    flags = {bus.req_valid_o, bus.req_we_o,
             bus.ld_ready_o, bus.st_ready_o,
             bus.ld_resp_valid_o, bus.req_kill_o,
             bus.stb_empty_o};
    tests++;
    if (flags !== 7'b0000001) begin
      $display("FAIL arst_flags got %b want %b",
               flags, 7'b0000001);
      fails++;
    end
    tests++;
    if ({bus.ld_resp_data_o, bus.req_wdata_o,
         bus.req_addr_tag_o} !== '0) begin
      $display("FAIL arst_data rdata=%h wdata=%h tag=%h want 0",
               bus.ld_resp_data_o, bus.req_wdata_o,
               bus.req_addr_tag_o);
      fails++;
    end
    step();
    idle_inputs();
    bus.req_ready_i = 1'b1;
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.stb_empty_o, bus.req_valid_o,
         bus.st_ready_o} !== 3'b101) begin
      $display("FAIL arst_after empty=%b req_valid=%b st_ready=%b want 1,0,1",
               bus.stb_empty_o, bus.req_valid_o,
               bus.st_ready_o);
      fails++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_stb_fill_drain();
    test_hazard();
    test_starvation();
    test_kill();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
